serial_loader: RTL and testbench
================================

Name: serial_loader

Overview:
- Receive-side counterpart of the BRAM-to-UART hex dumper: accepts the same ASCII record format over UART (115200/8/N/1) and writes the decoded bytes into a BRAM write port.
- Record format: `'$'`, 1–4 hex address digits, `'#'`, then hex byte pairs separated by optional spaces, terminated by CR (8'd13).
- Sits between the RX pin and a BRAM port (SP with WRE driven), so test memory images load without resynthesis.

Parameters:
- CLKS_PER_BIT, 208, clk cycles per UART bit (24 MHz / 115200, truncated).
- ADDR_W, 11, width of the BRAM byte address.

Ports:
- clk  input  1  system clock, 24 MHz.
- RESET  input  1  synchronous, active-high reset.
- RxPin  input  1  UART RX line; idles high; asynchronous to clk.
- WriteAddress  output  ADDR_W  BRAM byte address for the current write.
- WriteDATA  output  8  byte to write.
- WriteEnable  output  1  one-cycle write strobe; the address and data above are valid in that cycle.
- RecordDone  output  1  one-cycle pulse when a record ends in CR with no error.
- ParseError  output  1  one-cycle pulse on a syntax error.
- FrameError  output  1  one-cycle pulse on a bad stop bit.

Behaviour:
- Reset:
  - All outputs are 0.
  - Parser is in IDLE; RX is in WAIT_START.
  - The synchronizer flops are set to 1.
  - Reset asserted mid-byte or mid-record abandons everything. Bytes already written stay written.
- RX path:
  - Two-flop synchronizer on RxPin.
  - WAIT_START: a low level moves to START.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. If still low, go to DATA; if high, it was a glitch, return to WAIT_START.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample after one more bit period.
    - Stop bit 1: emit rx_valid for one cycle with rx_byte.
    - Stop bit 0: pulse FrameError, no rx_valid, return to WAIT_START.
  - No back-to-back limit: a new start bit is detected in the cycle after STOP completes.
- Parser: acts only on cycles where rx_valid is high. All outputs are registered, so each response appears exactly 1 clk after rx_valid.
- Global resync rule: `'$'` in any state clears addr_shift (16-bit) and the digit count, then enters ADDR. It never raises an error.
- IDLE: all characters other than `'$'` are ignored.
- ADDR:
  - Hex digit: addr_shift <= {addr_shift[11:0], nibble}; digit count +1.
  - A 5th digit is a ParseError; go to IDLE.
  - `'#'` with a digit count of 1–4: WriteAddress <= addr_shift[ADDR_W-1:0] (upper bits dropped); go to DATA_HI.
  - `'#'` with a digit count of 0 is a ParseError; go to IDLE.
  - Any other character is a ParseError; go to IDLE.
- DATA_HI:
  - Hex digit: latch as the high nibble; go to DATA_LO.
  - Space: stay in DATA_HI.
  - CR: pulse RecordDone; go to IDLE.
  - Any other character is a ParseError; go to IDLE.
- DATA_LO:
  - Hex digit: WriteDATA <= {hi, nibble}; WriteEnable = 1 for one cycle; go to DATA_HI.
  - Any other character (including space or CR) is a ParseError; go to IDLE. The pending high nibble is dropped.
- Address advance:
  - WriteAddress increments by 1 in the cycle after each WriteEnable.
  - It wraps modulo 2^ADDR_W (0x7FF to 0x000); wrap is not an error.
- Hex decode: `'0'`–`'9'` and `'A'`–`'F'` only, uppercase by default.
- ParseError and RecordDone are mutually exclusive. FrameError never changes parser state.

Optional Feature:
- Macro: SERIAL_LOADER_LOWER_EN.
- Defined: `'a'`–`'f'` are also accepted as hex digits, in both address and data.
- Undefined: lowercase letters are non-hex and take the error paths above.

Decomposition:
- Shared package / `include` file holds:
  - ASCII constants CH_DOLLAR, CH_HASH, CH_SPACE, CH_CR. These are shared with the dumper.
  - Parser state encodings PS_IDLE, PS_ADDR, PS_DATA_HI, PS_DATA_LO.
  - A hex-to-nibble function returning {valid, nibble}.
- One sub-module: serial_rx.
  - Ports: clk, RESET, rx, rx_byte[7:0], rx_valid, frame_err.
  - It is the mirror of the existing serial_tx.

Test Plan:
- Send `"$0010#A5 3C\r"` at 208 clk/bit:
  - Expect WriteEnable pulses with (addr 0x010, data 0xA5), then (addr 0x011, data 0x3C).
  - Expect one RecordDone pulse after CR.
  - Expect ParseError = 0 and FrameError = 0 throughout.
- Send `"$7FF#0102\r"`:
  - Expect writes (0x7FF, 0x01) and (0x000, 0x02).
  - The address wraps with no error.
- Send `"$12G#"`:
  - Expect a ParseError pulse 1 clk after the rx_valid for `'G'`.
  - Expect no writes.
  - A following `"$0#FF\r"` writes (0x000, 0xFF).
- Send `"$1#A$2#BB\r"`:
  - `'A'` is discarded silently, with no error.
  - Expect a single write (0x002, 0xBB) and RecordDone.
- Send byte 0x24 with stop bit forced to 0:
  - Expect a FrameError pulse, no rx_valid, and the parser stays in IDLE.
  - Hold RxPin low for 50 clk then release: no byte, no error.
- Assert RESET for 1 clk midway through the data bits of `'5'` in `"$5#"`:
  - All outputs read 0 from the next cycle.
  - A subsequent `"$5#11\r"` writes (0x005, 0x11).
  - With SERIAL_LOADER_LOWER_EN defined, `"$a#ff\r"` writes (0x00A, 0xFF); with it undefined, the same input gives a ParseError.

Source files
------------

// File: rtl/serial_loader_pkg.sv
// rtl/serial_loader_pkg.sv - shared ASCII constants, state encodings and hex decode for the serial loader
// Build option: SERIAL_LOADER_LOWER_EN also accepts 'a'-'f' as hex digits.
package serial_loader_pkg;

    // Record framing characters, shared with the hex dumper.
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_CR     = 8'h0D;

    typedef enum logic [1:0] {
        PS_IDLE    = 2'd0,
        PS_ADDR    = 2'd1,
        PS_DATA_HI = 2'd2,
        PS_DATA_LO = 2'd3
    } ps_e;

    typedef enum logic [1:0] {
        RX_WAIT_START = 2'd0,
        RX_START      = 2'd1,
        RX_DATA       = 2'd2,
        RX_STOP       = 2'd3
    } rx_state_e;

    // Returns {valid, nibble}; nibble is 0 when valid is 0.
    function automatic logic [4:0] hex_nibble(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, c[3:0]};
        end else if (c >= 8'h41 && c <= 8'h46) begin
            r = {1'b1, c[3:0] + 4'd9};
        end
`ifdef SERIAL_LOADER_LOWER_EN
        else if (c >= 8'h61 && c <= 8'h66) begin
            r = {1'b1, c[3:0] + 4'd9};
        end
`else
        else begin
            r = 5'd0;
        end
`endif
        return r;
    endfunction

endpackage

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - 8N1 UART receiver with glitch-rejecting start detect
// Ports: clk, RESET (sync, active high), rx (async line, idles high),
//        rx_byte (last received byte), rx_valid (1-cycle strobe), frame_err (1-cycle strobe, bad stop bit).
module serial_rx
    import serial_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 208
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             sync1_q, sync2_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_WAIT_START: begin
                cnt_d = '0;
                if (!sync2_q) state_d = RX_START;
            end
            RX_START: begin
                // Mid-start-bit resample: a high line here means the low was a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = sync2_q ? RX_WAIT_START : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    valid_d = sync2_q;
                    ferr_d  = !sync2_q;
                    state_d = RX_WAIT_START;
                end
            end
            default: state_d = RX_WAIT_START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= RX_WAIT_START;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_byte   = shift_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;

endmodule

// File: rtl/serial_loader.sv
// rtl/serial_loader.sv - UART hex-record loader driving a BRAM write port
// Record: '$' <1-4 hex addr digits> '#' <hex byte pairs, optional spaces> CR.
// Build option: SERIAL_LOADER_LOWER_EN accepts lowercase hex digits.
// Ports: clk, RESET (sync, active high), RxPin (async UART line),
//        WriteAddress/WriteDATA/WriteEnable (BRAM write port),
//        RecordDone, ParseError, FrameError (1-cycle status pulses).
module serial_loader
    import serial_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 208,
    parameter int ADDR_W       = 11
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              RxPin,
    output logic [ADDR_W-1:0] WriteAddress,
    output logic [7:0]        WriteDATA,
    output logic              WriteEnable,
    output logic              RecordDone,
    output logic              ParseError,
    output logic              FrameError
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;

    serial_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .RESET    (RESET),
        .rx       (RxPin),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .frame_err(frame_err)
    );

    ps_e               state_q, state_d;
    // Only the low ADDR_W bits of the digit shifter ever reach WriteAddress,
    // so higher digits are simply shifted out.
    logic [ADDR_W-1:0] addr_shift_q, addr_shift_d;
    logic [2:0]        dcnt_q, dcnt_d;
    logic [3:0]        hi_q, hi_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic [4:0]        hx;

    always_comb begin
        state_d      = state_q;
        addr_shift_d = addr_shift_q;
        dcnt_d       = dcnt_q;
        hi_d         = hi_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        we_d         = 1'b0;
        done_d       = 1'b0;
        perr_d       = 1'b0;
        ferr_d       = frame_err;
        hx           = hex_nibble(rx_byte);

        // Post-increment after each write; wraps naturally at 2^ADDR_W.
        if (we_q) waddr_d = waddr_q + ADDR_W'(1);

        if (rx_valid) begin
            if (rx_byte == CH_DOLLAR) begin
                addr_shift_d = '0;
                dcnt_d       = 3'd0;
                state_d      = PS_ADDR;
            end else begin
                case (state_q)
                    PS_IDLE: state_d = PS_IDLE;
                    PS_ADDR: begin
                        if (hx[4]) begin
                            if (dcnt_q == 3'd4) begin
                                perr_d  = 1'b1;
                                state_d = PS_IDLE;
                            end else begin
                                addr_shift_d = {addr_shift_q[ADDR_W-5:0], hx[3:0]};
                                dcnt_d       = dcnt_q + 3'd1;
                            end
                        end else if (rx_byte == CH_HASH && dcnt_q != 3'd0) begin
                            waddr_d = addr_shift_q;
                            state_d = PS_DATA_HI;
                        end else begin
                            perr_d  = 1'b1;
                            state_d = PS_IDLE;
                        end
                    end
                    PS_DATA_HI: begin
                        if (hx[4]) begin
                            hi_d    = hx[3:0];
                            state_d = PS_DATA_LO;
                        end else if (rx_byte == CH_SPACE) begin
                            state_d = PS_DATA_HI;
                        end else if (rx_byte == CH_CR) begin
                            done_d  = 1'b1;
                            state_d = PS_IDLE;
                        end else begin
                            perr_d  = 1'b1;
                            state_d = PS_IDLE;
                        end
                    end
                    PS_DATA_LO: begin
                        if (hx[4]) begin
                            wdata_d = {hi_q, hx[3:0]};
                            we_d    = 1'b1;
                            state_d = PS_DATA_HI;
                        end else begin
                            perr_d  = 1'b1;
                            state_d = PS_IDLE;
                        end
                    end
                    default: state_d = PS_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q      <= PS_IDLE;
            addr_shift_q <= '0;
            dcnt_q       <= 3'd0;
            hi_q         <= 4'd0;
            waddr_q      <= '0;
            wdata_q      <= 8'd0;
            we_q         <= 1'b0;
            done_q       <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_shift_q <= addr_shift_d;
            dcnt_q       <= dcnt_d;
            hi_q         <= hi_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            done_q       <= done_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
        end
    end

    assign WriteAddress = waddr_q;
    assign WriteDATA    = wdata_q;
    assign WriteEnable  = we_q;
    assign RecordDone   = done_q;
    assign ParseError   = perr_q;
    assign FrameError   = ferr_q;

endmodule

// File: tb/tb_serial_loader.sv
// tb/tb_serial_loader.sv - scoreboard bench for serial_loader with directed and random records
module tb_serial_loader;

    localparam int CPB = 24;
    localparam int AW  = 11;

    logic          clk = 1'b0;
    logic          RESET;
    logic          RxPin;
    logic [AW-1:0] WriteAddress;
    logic [7:0]    WriteDATA;
    logic          WriteEnable;
    logic          RecordDone;
    logic          ParseError;
    logic          FrameError;

    serial_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk         (clk),
        .RESET       (RESET),
        .RxPin       (RxPin),
        .WriteAddress(WriteAddress),
        .WriteDATA   (WriteDATA),
        .WriteEnable (WriteEnable),
        .RecordDone  (RecordDone),
        .ParseError  (ParseError),
        .FrameError  (FrameError)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_WR, EV_DONE, EV_PERR, EV_FERR} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       addr;
        int       data;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    bit  prev_rxv = 1'b0;

    function automatic void expect_ev(ev_kind_e k, int a, int d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    function automatic void expect_wr(int a, int d);
        expect_ev(EV_WR, a % (1 << AW), d);
    endfunction

    task automatic got(input ev_kind_e k, input int a, input int d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event got=%s addr=%0h data=%0h required=none", k.name(), a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (k == EV_WR && (e.addr != a || e.data != d))) begin
                failures++;
                $display("FAIL event got=%s addr=%0h data=%0h required=%s addr=%0h data=%0h",
                         k.name(), a, d, e.kind.name(), e.addr, e.data);
            end
        end
    endtask

    // Monitor: every parser response must follow an rx_valid by exactly one clock.
    always @(negedge clk) begin
        if (!RESET) begin
            if (WriteEnable || RecordDone || ParseError) begin
                checks++;
                if (!prev_rxv) begin
                    failures++;
                    $display("FAIL latency got=no_rx_valid_prev_cycle required=rx_valid_prev_cycle");
                end
            end
            if (RecordDone && ParseError) begin
                checks++;
                failures++;
                $display("FAIL exclusive got=done_and_perr required=at_most_one");
            end
            if (WriteEnable) got(EV_WR, int'(WriteAddress), int'(WriteDATA));
            if (RecordDone)  got(EV_DONE, 0, 0);
            if (ParseError)  got(EV_PERR, 0, 0);
            if (FrameError)  got(EV_FERR, 0, 0);
        end
        prev_rxv = dut.u_rx.rx_valid;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_addr"}, int'(WriteAddress), 0);
        chk({tag, "_data"}, int'(WriteDATA), 0);
        chk({tag, "_we"},   int'(WriteEnable), 0);
        chk({tag, "_done"}, int'(RecordDone), 0);
        chk({tag, "_perr"}, int'(ParseError), 0);
        chk({tag, "_ferr"}, int'(FrameError), 0);
    endtask

    function automatic byte hexch(int n);
        string h;
        h = "0123456789ABCDEF";
        return h[n];
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        @(negedge clk);
        RxPin = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RxPin = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (bad_stop) begin
            RxPin = 1'b0;
            repeat (CPB * 3 / 4) @(negedge clk);
            RxPin = 1'b1;
            repeat (CPB * 2) @(negedge clk);
        end else begin
            RxPin = 1'b1;
            repeat (CPB + $urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < CPB * 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_%s pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Builds a random record from fields and queues the responses those fields imply.
    task automatic rand_record(input int idx);
        int    nd, av, base, nb, errpos, d;
        bit    err;
        string s, bad;
        nd   = $urandom_range(1, 4);
        av   = $urandom & ((1 << (4 * nd)) - 1);
        base = av % (1 << AW);
        nb   = $urandom_range(0, 3);
        err  = ($urandom_range(0, 3) == 0);
        errpos = $urandom_range(0, nb);
        bad  = "GZ#*";
        s = "$";
        for (int i = nd - 1; i >= 0; i--) s = {s, $sformatf("%c", hexch((av >> (4 * i)) & 15))};
        s = {s, "#"};
        for (int i = 0; i <= nb; i++) begin
            if (err && i == errpos) begin
                s = {s, $sformatf("%c", bad[$urandom_range(0, 3)])};
                expect_ev(EV_PERR, 0, 0);
                break;
            end
            if (i == nb) begin
                s = {s, "\r"};
                expect_ev(EV_DONE, 0, 0);
            end else begin
                if ($urandom_range(0, 1) == 1) s = {s, " "};
                d = $urandom_range(0, 255);
                s = {s, $sformatf("%c%c", hexch(d >> 4), hexch(d & 15))};
                expect_wr(base + i, d);
            end
        end
        send_str(s);
        drain($sformatf("rand%0d", idx));
    endtask

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog got=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        RESET = 1'b1;
        RxPin = 1'b1;
        repeat (4) @(negedge clk);
        chk_outputs_zero("reset");
        RESET = 1'b0;
        repeat (CPB) @(negedge clk);

        expect_wr(12'h010, 8'hA5);
        expect_wr(12'h011, 8'h3C);
        expect_ev(EV_DONE, 0, 0);
        send_str("$0010#A5 3C\r");
        drain("basic");

        expect_wr(12'h7FF, 8'h01);
        expect_wr(12'h800, 8'h02);
        expect_ev(EV_DONE, 0, 0);
        send_str("$7FF#0102\r");
        drain("wrap");

        expect_ev(EV_PERR, 0, 0);
        send_str("$12G#");
        drain("bad_addr_digit");
        expect_wr(0, 8'hFF);
        expect_ev(EV_DONE, 0, 0);
        send_str("$0#FF\r");
        drain("after_error");

        expect_wr(2, 8'hBB);
        expect_ev(EV_DONE, 0, 0);
        send_str("$1#A$2#BB\r");
        drain("resync");

        // Reset in the middle of the data bits of '5' (0x35) after '$'.
        send_str("$");
        @(negedge clk);
        RxPin = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            RxPin = (8'h35 >> i) & 1;
            repeat (CPB) @(negedge clk);
        end
        RESET = 1'b1;
        @(negedge clk);
        RESET = 1'b0;
        RxPin = 1'b1;
        chk_outputs_zero("midreset");
        repeat (CPB * 3) @(negedge clk);
        send_str("5#11\r");
        drain("post_reset_idle");
        expect_wr(5, 8'h11);
        expect_ev(EV_DONE, 0, 0);
        send_str("$5#11\r");
        drain("post_reset");

        expect_ev(EV_PERR, 0, 0);
        send_str("$12345#");
        drain("five_digits");
        expect_ev(EV_PERR, 0, 0);
        send_str("$#");
        drain("zero_digits");
        expect_ev(EV_PERR, 0, 0);
        send_str("$1#A 5\r");
        drain("space_in_lo");
        expect_wr(12'h7FF, 8'h00);
        expect_ev(EV_DONE, 0, 0);
        send_str("$FFFF#00\r");
        drain("four_digits_trunc");
        expect_ev(EV_DONE, 0, 0);
        send_str("$1#\r");
        drain("empty_record");

        expect_ev(EV_FERR, 0, 0);
        send_byte(8'h24, 1'b1);
        drain("frame_err");
        send_str("#11\r");
        drain("idle_after_frame_err");

        @(negedge clk);
        RxPin = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        RxPin = 1'b1;
        repeat (CPB * 12) @(negedge clk);
        drain("glitch");

`ifdef SERIAL_LOADER_LOWER_EN
        expect_wr(12'h00A, 8'hFF);
        expect_ev(EV_DONE, 0, 0);
`else
        expect_ev(EV_PERR, 0, 0);
`endif
        send_str("$a#ff\r");
        drain("lowercase");

        for (int r = 0; r < 6; r++) rand_record(r);

        repeat (CPB * 4) @(negedge clk);
        drain("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
